ahb_wait_slave: RTL and testbench

- AHB-Lite memory slave that sits directly downstream of Dmac_Top on the master bus. It is the destination and source for DMA bursts.
- Byte-addressed little-endian memory with write strobes and runtime-programmable wait states.
- Two-cycle ERROR responses on illegal accesses.
- Replaces the zero-wait mock peripherals so DMAC handling of HREADY stalls and HRESP errors is exercised.

---
 rtl/ahb_pkg.sv | 39 +++
 rtl/ahb_wait_slave_if.sv | 26 ++
 rtl/ahb_strb_mem.sv | 25 ++
 rtl/ahb_wait_slave.sv | 77 +++++++
 tb/tb_ahb_wait_slave.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite transfer types and slave state encoding
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01
  } hresp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_t;

  // Unsupported sizes and misaligned or out-of-range accesses are rejected.
  function automatic logic access_error(input logic in_range, input logic [2:0] size,
                                        input logic [1:0] lsb);
    case (size)
      SIZE_BYTE: return !in_range;
      SIZE_HALF: return !in_range || lsb[0];
      SIZE_WORD: return !in_range || (lsb != 2'b00);
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_wait_slave_if.sv
// rtl/ahb_wait_slave_if.sv - AHB-Lite slave port bundle
interface ahb_wait_slave_if #(
  parameter int ADDR_W = 32
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic              HREADYIN;
  logic [31:0]       HWDATA;
  logic [3:0]        HWSTRB;
  logic [31:0]       HRDATA;
  logic              HREADYOUT;
  logic [1:0]        HRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADYIN, HWDATA, HWSTRB,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADYIN, HWDATA, HWSTRB,
    input  HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_strb_mem.sv
// rtl/ahb_strb_mem.sv - byte array with strobed word write and combinational word read
module ahb_strb_mem #(
  parameter int DEPTH  = 256,
  parameter int WORD_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [WORD_W-1:0] word,
  input  logic [31:0]       wdata,
  input  logic [3:0]        strb,
  output logic [31:0]       rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int c = 0; c < 4; c++) begin
        if (strb[c]) mem[{word, 2'(c)}] <= wdata[8*c +: 8];
      end
    end
  end

  assign rdata = {mem[{word, 2'd3}], mem[{word, 2'd2}], mem[{word, 2'd1}], mem[{word, 2'd0}]};

endmodule

// File: rtl/ahb_wait_slave.sv
// rtl/ahb_wait_slave.sv - AHB-Lite memory slave with programmable wait states
// and two-cycle ERROR responses.
module ahb_wait_slave
  import ahb_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            wait_cfg,
  ahb_wait_slave_if.slave       bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int WW = (AW > 2) ? AW - 2 : 1;

  slave_state_t  state;
  logic [2:0]    wait_cnt;
  logic [WW-1:0] word_q;
  logic          write_q;
  logic          accept;
  logic          in_range;
  logic          err;
  logic [31:0]   rd_word;

  assign accept   = bus.HSEL & bus.HREADYIN &
                    ((bus.HTRANS == TRANS_NONSEQ) | (bus.HTRANS == TRANS_SEQ));
  assign in_range = bus.HADDR < ADDR_W'(MEM_DEPTH);
  assign err      = access_error(in_range, bus.HSIZE, bus.HADDR[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      word_q   <= '0;
      write_q  <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) state <= ST_DATA;
        end
        ST_ERR1: state <= ST_ERR2;
        // IDLE, DATA and ERR2 all present HREADYOUT=1, so each can take a new address phase.
        default: begin
          if (accept) begin
            word_q   <= WW'(bus.HADDR[ADDR_W-1:2]);
            write_q  <= bus.HWRITE;
            wait_cnt <= wait_cfg;
            if (err)                  state <= ST_ERR1;
            else if (wait_cfg != 3'd0) state <= ST_WAIT;
            else                       state <= ST_DATA;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  ahb_strb_mem #(
    .DEPTH  (MEM_DEPTH),
    .WORD_W (WW)
  ) u_mem (
    .clk   (clk),
    .we    ((state == ST_DATA) && write_q),
    .word  (word_q),
    .wdata (bus.HWDATA),
    .strb  (bus.HWSTRB),
    .rdata (rd_word)
  );

  assign bus.HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
  assign bus.HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
  assign bus.HRDATA    = (state == ST_DATA) ? rd_word : 32'h0;

endmodule

// File: tb/tb_ahb_wait_slave.sv
// tb/tb_ahb_wait_slave.sv - self-checking bench for ahb_wait_slave
module tb_ahb_wait_slave;
  import ahb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] wait_cfg;

  ahb_wait_slave_if #(.ADDR_W(32)) bus ();
  assign bus.HREADYIN = bus.HREADYOUT;

  ahb_wait_slave #(.MEM_DEPTH(256), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .wait_cfg (wait_cfg),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [2:0]  wcfg;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } op_t;

  typedef struct {
    bit          rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  op_t         ops[$];
  exp_t        expq[$];
  logic [7:0]  ref_mem [256];
  int          checks = 0;
  int          errors = 0;
  int          low_cycles = 0;
  int          err_cycles = 0;
  int          run_cycles = 0;
  logic [31:0] last_rdata = 32'h0;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 11);
  endfunction

  function automatic op_t mk(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                             input logic [2:0] wcfg, input logic [31:0] wdata,
                             input logic [3:0] strb);
    op_t o;
    o.wr = wr; o.addr = addr; o.size = size; o.wcfg = wcfg; o.wdata = wdata; o.strb = strb;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Expected per-cycle response of one accepted transfer; also updates the reference memory.
  task automatic push_expect(input op_t o);
    logic        ok;
    int          a;
    logic [31:0] w;
    ok = (o.addr < 32'd256) && (o.size <= 3'd2) && !(o.size == 3'd1 && o.addr[0]) &&
         !(o.size == 3'd2 && o.addr[1:0] != 2'b00);
    if (!ok) begin
      expq.push_back('{1'b0, 2'b01, 32'h0});
      expq.push_back('{1'b1, 2'b01, 32'h0});
    end else begin
      a = int'(o.addr) & ~3;
      for (int i = 0; i < int'(o.wcfg); i++) expq.push_back('{1'b0, 2'b00, 32'h0});
      w = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
      expq.push_back('{1'b1, 2'b00, w});
      if (o.wr) begin
        for (int c = 0; c < 4; c++) if (o.strb[c]) ref_mem[a+c] = o.wdata[8*c +: 8];
      end
    end
  endtask

  task automatic drive_idle();
    bus.HSEL = 1'b0; bus.HTRANS = TRANS_IDLE; bus.HADDR = 32'h0; bus.HWRITE = 1'b0;
    bus.HSIZE = 3'd0; bus.HWDATA = 32'h0; bus.HWSTRB = 4'h0; wait_cfg = 3'd7;
  endtask

  task automatic run_ops();
    int   cur, nxt, guard;
    logic r;
    cur = -1; nxt = 0; guard = 0;
    run_cycles = 0; low_cycles = 0; err_cycles = 0; last_rdata = 32'h0;
    while (cur >= 0 || nxt < ops.size()) begin
      if (nxt < ops.size()) begin
        bus.HSEL   = 1'b1;
        bus.HTRANS = (nxt == 0) ? TRANS_NONSEQ : TRANS_SEQ;
        bus.HADDR  = ops[nxt].addr;
        bus.HWRITE = ops[nxt].wr;
        bus.HSIZE  = ops[nxt].size;
        wait_cfg   = ops[nxt].wcfg;
      end else begin
        bus.HSEL = 1'b0; bus.HTRANS = TRANS_IDLE; bus.HADDR = 32'h0; wait_cfg = 3'd7;
      end
      bus.HWDATA = (cur >= 0) ? ops[cur].wdata : 32'h0;
      bus.HWSTRB = (cur >= 0) ? ops[cur].strb : 4'h0;
      @(negedge clk);
      r = bus.HREADYOUT;
      @(posedge clk);
      #1;
      run_cycles++;
      if (r) begin
        if (nxt < ops.size()) begin
          push_expect(ops[nxt]);
          cur = nxt;
          nxt++;
        end else begin
          cur = -1;
        end
      end
      guard++;
      if (guard > 100) begin
        check("engine_timeout", 32'd1, 32'd0);
        break;
      end
    end
    drive_idle();
    ops.delete();
  endtask

  initial begin
    exp_t e;
    bit   popped;
    forever begin
      @(negedge clk);
      if (!rst) begin
        popped = expq.size() > 0;
        if (popped) e = expq.pop_front();
        else        e = '{1'b1, 2'b00, 32'h0};
        check("hreadyout", 32'(bus.HREADYOUT), 32'(e.rdy));
        check("hresp", 32'(bus.HRESP), 32'(e.resp));
        check("hrdata", bus.HRDATA, e.rdata);
        if (!bus.HREADYOUT) low_cycles++;
        if (bus.HRESP == 2'b01) err_cycles++;
        if (popped && e.rdy && e.resp == 2'b00) last_rdata = bus.HRDATA;
      end
    end
  end

  initial begin
    int mism;
    drive_idle();
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = pat(i);
      dut.u_mem.mem[i] = pat(i);
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("reset_hresp", 32'(bus.HRESP), 32'd0);
    check("reset_hrdata", bus.HRDATA, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    ops.push_back(mk(1'b1, 32'h10, 3'd2, 3'd0, 32'hDEADBEEF, 4'hF));
    run_ops();
    check("zw_low_cycles", 32'(low_cycles), 32'd0);
    check("zw_mem10", 32'(dut.u_mem.mem[16]), 32'hEF);
    check("zw_mem11", 32'(dut.u_mem.mem[17]), 32'hBE);
    check("zw_mem12", 32'(dut.u_mem.mem[18]), 32'hAD);
    check("zw_mem13", 32'(dut.u_mem.mem[19]), 32'hDE);

    {ref_mem[35], ref_mem[34], ref_mem[33], ref_mem[32]} = 32'h11223344;
    {dut.u_mem.mem[35], dut.u_mem.mem[34], dut.u_mem.mem[33], dut.u_mem.mem[32]} = 32'h11223344;
    ops.push_back(mk(1'b0, 32'h20, 3'd2, 3'd3, 32'h0, 4'h0));
    run_ops();
    check("ws_low_cycles", 32'(low_cycles), 32'd3);
    check("ws_rdata", last_rdata, 32'h11223344);

    ops.push_back(mk(1'b1, 32'h05, 3'd0, 3'd1, 32'hAABBCCDD, 4'b0010));
    run_ops();
    check("sb_low_cycles", 32'(low_cycles), 32'd1);
    check("sb_mem05", 32'(dut.u_mem.mem[5]), 32'hCC);
    check("sb_mem04", 32'(dut.u_mem.mem[4]), 32'(pat(4)));
    check("sb_mem06", 32'(dut.u_mem.mem[6]), 32'(pat(6)));
    check("sb_mem07", 32'(dut.u_mem.mem[7]), 32'(pat(7)));

    ops.push_back(mk(1'b0, 32'h102, 3'd2, 3'd5, 32'h0, 4'h0));
    run_ops();
    check("err_oor_low", 32'(low_cycles), 32'd1);
    check("err_oor_resp", 32'(err_cycles), 32'd2);

    ops.push_back(mk(1'b1, 32'h03, 3'd1, 3'd4, 32'h55555555, 4'hF));
    run_ops();
    check("err_half_low", 32'(low_cycles), 32'd1);
    check("err_half_resp", 32'(err_cycles), 32'd2);
    check("err_half_mem02", 32'(dut.u_mem.mem[2]), 32'(pat(2)));
    check("err_half_mem03", 32'(dut.u_mem.mem[3]), 32'(pat(3)));

    ops.push_back(mk(1'b1, 32'h40, 3'd2, 3'd0, 32'hA0A1A2A3, 4'hF));
    ops.push_back(mk(1'b1, 32'h44, 3'd2, 3'd0, 32'hB0B1B2B3, 4'hF));
    ops.push_back(mk(1'b1, 32'h48, 3'd2, 3'd0, 32'hC0C1C2C3, 4'hF));
    ops.push_back(mk(1'b1, 32'h4C, 3'd2, 3'd0, 32'hD0D1D2D3, 4'hF));
    ops.push_back(mk(1'b0, 32'h4C, 3'd2, 3'd0, 32'h0, 4'h0));
    run_ops();
    check("burst_low_cycles", 32'(low_cycles), 32'd0);
    check("burst_cycles", 32'(run_cycles), 32'd6);
    check("burst_rdata", last_rdata, 32'hD0D1D2D3);

    ops.push_back(mk(1'b1, 32'h30, 3'd2, 3'd2, 32'h99999999, 4'h0));
    ops.push_back(mk(1'b0, 32'h08, 3'd3, 3'd0, 32'h0, 4'h0));
    ops.push_back(mk(1'b0, 32'h10, 3'd2, 3'd7, 32'h0, 4'h0));
    run_ops();
    check("nostrb_mem30", 32'(dut.u_mem.mem[48]), 32'(pat(48)));
    check("mix_low_cycles", 32'(low_cycles), 32'd10);
    check("mix_rdata", last_rdata, 32'hDEADBEEF);

    bus.HSEL = 1'b1; bus.HTRANS = TRANS_NONSEQ; bus.HADDR = 32'h80; bus.HWRITE = 1'b1;
    bus.HSIZE = 3'd2; wait_cfg = 3'd5;
    @(posedge clk);
    #1;
    push_expect(mk(1'b1, 32'h80, 3'd2, 3'd5, 32'h12345678, 4'hF));
    drive_idle();
    bus.HWDATA = 32'h12345678; bus.HWSTRB = 4'hF;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("rst_hresp", 32'(bus.HRESP), 32'd0);
    expq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle();
    for (int i = 128; i < 132; i++) ref_mem[i] = pat(i);
    check("rst_mem80", 32'(dut.u_mem.mem[128]), 32'(pat(128)));
    ops.push_back(mk(1'b0, 32'h80, 3'd2, 3'd0, 32'h0, 4'h0));
    run_ops();
    check("rst_rdata", last_rdata, {pat(131), pat(130), pat(129), pat(128)});

    mism = 0;
    for (int i = 0; i < 256; i++) if (dut.u_mem.mem[i] !== ref_mem[i]) mism++;
    check("mem_image", 32'(mism), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
